// File: rtl/uart8_txrx.sv
// uart8_txrx: 8N1 UART with independent receiver (16x oversampled) and transmitter on one baud generator.
// Define UART8_RX_MAJORITY_EN to take each received bit as a 2-of-3 majority of neighbouring ticks.
module uart8_txrx #(
  parameter int CLOCK_RATE         = 100000000,
  parameter int BAUD_RATE          = 9600,
  parameter int RX_OVERSAMPLE_RATE = 16
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       rxEn,
  input  logic       rx,
  output logic       rxBusy,
  output logic       rxDone,
  output logic       rxErr,
  output logic [7:0] out,
  input  logic       txEn,
  input  logic       txStart,
  input  logic [7:0] in,
  output logic       txBusy,
  output logic       txDone,
  output logic       tx
);

  localparam int RX_DIV = CLOCK_RATE / (BAUD_RATE * RX_OVERSAMPLE_RATE);
  localparam int TX_DIV = CLOCK_RATE / BAUD_RATE;
  localparam int RXW    = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;
  localparam int TXW    = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;
  localparam logic [RXW-1:0] RX_LAST = RXW'(RX_DIV - 1);
  localparam logic [TXW-1:0] TX_LAST = TXW'(TX_DIV - 1);

`ifdef UART8_RX_MAJORITY_EN
  // Majority needs one tick past the centre, so decisions slide one tick later.
  localparam logic [3:0] START_DECIDE = 4'd8;
  localparam logic [3:0] BIT_DECIDE   = 4'd0;
`else
  localparam logic [3:0] START_DECIDE = 4'd7;
  localparam logic [3:0] BIT_DECIDE   = 4'd15;
`endif
  localparam logic [3:0] DATA_ENTRY = BIT_DECIDE + 4'd1;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} RxState;
  typedef enum logic [2:0] {TX_IDLE, TX_WAIT, TX_START, TX_DATA, TX_STOP} TxState;

  logic [RXW-1:0] rxDivCnt;
  logic [TXW-1:0] txDivCnt;
  logic           rxTick;
  logic           txTick;
  logic [1:0]     rxSync;
  logic           rxS;
  logic           rxSample;

  RxState     rxState, rxStateNext;
  logic [3:0] rxCnt, rxCntNext;
  logic [2:0] rxBit, rxBitNext;
  logic [7:0] rxShift, rxShiftNext;
  logic [7:0] outNext;
  logic       rxErrNext, rxDoneNext;
  logic       rxArmed, rxArmedNext;

  TxState     txState, txStateNext;
  logic [2:0] txBit, txBitNext;
  logic [7:0] txData, txDataNext;
  logic       txLineNext, txDoneNext;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rxDivCnt <= '0;
      txDivCnt <= '0;
      rxTick   <= 1'b0;
      txTick   <= 1'b0;
      rxSync   <= 2'b00;
    end else begin
      rxTick <= 1'b0;
      txTick <= 1'b0;
      if (rxDivCnt == RX_LAST) begin
        rxDivCnt <= '0;
        rxTick   <= 1'b1;
      end else begin
        rxDivCnt <= rxDivCnt + 1'b1;
      end
      if (txDivCnt == TX_LAST) begin
        txDivCnt <= '0;
        txTick   <= 1'b1;
      end else begin
        txDivCnt <= txDivCnt + 1'b1;
      end
      rxSync <= {rxSync[0], rx};
    end
  end

  assign rxS = rxSync[1];

`ifdef UART8_RX_MAJORITY_EN
  logic [1:0] rxWin;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) rxWin <= 2'b00;
    else if (rxTick) rxWin <= {rxWin[0], rxS};
  end

  assign rxSample = (rxWin[1] & rxWin[0]) | ((rxWin[1] | rxWin[0]) & rxS);
`else
  assign rxSample = rxS;
`endif

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rxState <= RX_IDLE;
      rxCnt   <= 4'd0;
      rxBit   <= 3'd0;
      rxShift <= 8'd0;
      out     <= 8'd0;
      rxErr   <= 1'b0;
      rxDone  <= 1'b0;
      rxArmed <= 1'b0;
    end else begin
      rxState <= rxStateNext;
      rxCnt   <= rxCntNext;
      rxBit   <= rxBitNext;
      rxShift <= rxShiftNext;
      out     <= outNext;
      rxErr   <= rxErrNext;
      rxDone  <= rxDoneNext;
      rxArmed <= rxArmedNext;
    end
  end

  // A start needs a high sample first (rxArmed), so X or a stuck-low line never starts a frame.
  always_comb begin
    rxStateNext = rxState;
    rxCntNext   = rxCnt;
    rxBitNext   = rxBit;
    rxShiftNext = rxShift;
    outNext     = out;
    rxErrNext   = rxErr;
    rxDoneNext  = 1'b0;
    rxArmedNext = rxArmed;
    if (!rxEn) begin
      rxStateNext = RX_IDLE;
      rxArmedNext = 1'b0;
    end else if (rxTick) begin
      case (rxState)
        RX_IDLE: begin
          if (rxS == 1'b1) begin
            rxArmedNext = 1'b1;
          end else if (rxArmed && rxS == 1'b0) begin
            rxStateNext = RX_START;
            rxCntNext   = 4'd0;
            rxErrNext   = 1'b0;
            rxArmedNext = 1'b0;
          end
        end
        RX_START: begin
          if (rxCnt == START_DECIDE) begin
            if (rxSample == 1'b0) begin
              rxStateNext = RX_DATA;
              rxCntNext   = DATA_ENTRY;
              rxBitNext   = 3'd0;
            end else begin
              rxStateNext = RX_IDLE;
            end
          end else begin
            rxCntNext = rxCnt + 4'd1;
          end
        end
        RX_DATA: begin
          rxCntNext = rxCnt + 4'd1;
          if (rxCnt == BIT_DECIDE) begin
            rxShiftNext = {rxSample, rxShift[7:1]};
            rxBitNext   = rxBit + 3'd1;
            if (rxBit == 3'd7) rxStateNext = RX_STOP;
          end
        end
        RX_STOP: begin
          rxCntNext = rxCnt + 4'd1;
          if (rxCnt == BIT_DECIDE) begin
            outNext     = rxShift;
            rxDoneNext  = 1'b1;
            rxErrNext   = ~rxSample;
            rxStateNext = RX_IDLE;
          end
        end
        default: rxStateNext = RX_IDLE;
      endcase
    end
  end

  assign rxBusy = (rxState != RX_IDLE);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      txState <= TX_IDLE;
      txBit   <= 3'd0;
      txData  <= 8'd0;
      tx      <= 1'b1;
      txDone  <= 1'b0;
    end else begin
      txState <= txStateNext;
      txBit   <= txBitNext;
      txData  <= txDataNext;
      tx      <= txLineNext;
      txDone  <= txDoneNext;
    end
  end

  // txData shifts right as bits go out; a held txStart at stop end chains straight into the next start bit.
  always_comb begin
    txStateNext = txState;
    txBitNext   = txBit;
    txDataNext  = txData;
    txLineNext  = tx;
    txDoneNext  = 1'b0;
    if (!txEn) begin
      txStateNext = TX_IDLE;
      txLineNext  = 1'b1;
    end else begin
      case (txState)
        TX_IDLE: begin
          txLineNext = 1'b1;
          if (txStart) begin
            txDataNext  = in;
            txStateNext = TX_WAIT;
          end
        end
        TX_WAIT: begin
          if (txTick) begin
            txLineNext  = 1'b0;
            txStateNext = TX_START;
          end
        end
        TX_START: begin
          if (txTick) begin
            txLineNext  = txData[0];
            txDataNext  = {1'b0, txData[7:1]};
            txBitNext   = 3'd0;
            txStateNext = TX_DATA;
          end
        end
        TX_DATA: begin
          if (txTick) begin
            if (txBit == 3'd7) begin
              txLineNext  = 1'b1;
              txStateNext = TX_STOP;
            end else begin
              txLineNext = txData[0];
              txDataNext = {1'b0, txData[7:1]};
              txBitNext  = txBit + 3'd1;
            end
          end
        end
        TX_STOP: begin
          if (txTick) begin
            txDoneNext = 1'b1;
            if (txStart) begin
              txDataNext  = in;
              txLineNext  = 1'b0;
              txStateNext = TX_START;
            end else begin
              txStateNext = TX_IDLE;
            end
          end
        end
        default: begin
          txStateNext = TX_IDLE;
          txLineNext  = 1'b1;
        end
      endcase
    end
  end

  assign txBusy = (txState != TX_IDLE);

endmodule

// File: tb/tb_uart8_txrx.sv
// tb_uart8_txrx: scoreboard bench for uart8_txrx at 12 MHz / 9600 baud.
// Receive frames are queued when driven and checked on rxDone; transmit bits are queued and checked mid-bit.
`timescale 1ns/1ps
module tb_uart8_txrx;

  localparam int CLOCK_RATE = 12000000;
  localparam int BAUD_RATE  = 9600;
  localparam int RX_BIT     = (CLOCK_RATE / (BAUD_RATE * 16)) * 16;
  localparam int TX_BIT     = CLOCK_RATE / BAUD_RATE;
  localparam int SLOW_BIT   = (RX_BIT * 103) / 100;

  logic       clk;
  logic       rstN;
  logic       rxEn;
  logic       rx;
  logic       rxBusy;
  logic       rxDone;
  logic       rxErr;
  logic [7:0] out;
  logic       txEn;
  logic       txStart;
  logic [7:0] in;
  logic       txBusy;
  logic       txDone;
  logic       tx;

  int testsRun   = 0;
  int failures   = 0;
  int rxDoneCnt  = 0;
  int txDoneCnt  = 0;
  int txBusyClks = 0;

  logic [8:0] rxExpQ[$];
  logic       txExpQ[$];

  uart8_txrx #(
    .CLOCK_RATE(CLOCK_RATE),
    .BAUD_RATE(BAUD_RATE),
    .RX_OVERSAMPLE_RATE(16)
  ) dut (
    .clk(clk),
    .rstN(rstN),
    .rxEn(rxEn),
    .rx(rx),
    .rxBusy(rxBusy),
    .rxDone(rxDone),
    .rxErr(rxErr),
    .out(out),
    .txEn(txEn),
    .txStart(txStart),
    .in(in),
    .txBusy(txBusy),
    .txDone(txDone),
    .tx(tx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Serial rx driver: start bit, nBits data bits LSB first, and a stop bit when the frame is complete.
  task automatic applyStimulus(input logic [7:0] data, input logic stopLevel, input int nBits, input int bitClks);
    rx = 1'b0;
    repeat (bitClks / 2) @(negedge clk);
    checkOutput("rxBusyStart", {31'd0, rxBusy}, 32'd1);
    checkOutput("rxErrClearOnStart", {31'd0, rxErr}, 32'd0);
    repeat (bitClks - bitClks / 2) @(negedge clk);
    for (int i = 0; i < nBits; i++) begin
      rx = data[i];
      repeat (bitClks / 2) @(negedge clk);
      checkOutput("rxBusyData", {31'd0, rxBusy}, 32'd1);
      repeat (bitClks - bitClks / 2) @(negedge clk);
    end
    if (nBits == 8) begin
      rx = stopLevel;
      repeat (bitClks) @(negedge clk);
    end
  endtask

  always @(negedge clk) begin
    if (rstN && rxDone) begin
      logic [8:0] e;
      rxDoneCnt++;
      if (rxExpQ.size() == 0) begin
        checkOutput("rxUnexpectedDone", 32'd1, 32'd0);
      end else begin
        e = rxExpQ.pop_front();
        checkOutput("rxData", {24'd0, out}, {24'd0, e[7:0]});
        checkOutput("rxErrFlag", {31'd0, rxErr}, {31'd0, e[8]});
      end
    end
  end

  always @(negedge clk) begin
    if (rstN && txDone) txDoneCnt++;
    if (rstN && txBusy) txBusyClks++;
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstN    = 1'b0;
    rxEn    = 1'b1;
    txEn    = 1'b1;
    txStart = 1'b0;
    in      = 8'h00;
    repeat (5) @(negedge clk);
    checkOutput("rstRxBusy", {31'd0, rxBusy}, 32'd0);
    checkOutput("rstRxDone", {31'd0, rxDone}, 32'd0);
    checkOutput("rstRxErr", {31'd0, rxErr}, 32'd0);
    checkOutput("rstOut", {24'd0, out}, 32'd0);
    checkOutput("rstTxBusy", {31'd0, txBusy}, 32'd0);
    checkOutput("rstTxDone", {31'd0, txDone}, 32'd0);
    checkOutput("rstTx", {31'd0, tx}, 32'd1);
    rstN = 1'b1;
    repeat (300) @(negedge clk);
    checkOutput("noStartOnX", {31'd0, rxBusy}, 32'd0);

    fork
      begin : rxSeq
        rx = 1'b1;
        repeat (RX_BIT) @(negedge clk);

        applyStimulus(8'b00110101, 1'b1, 5, SLOW_BIT);
        checkOutput("partialBusy", {31'd0, rxBusy}, 32'd1);
        checkOutput("partialNoDone", rxDoneCnt, 32'd0);
        checkOutput("partialOut", {24'd0, out}, 32'd0);
        rxEn = 1'b0;
        rx   = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("abortBusy", {31'd0, rxBusy}, 32'd0);
        checkOutput("abortOut", {24'd0, out}, 32'd0);
        rxEn = 1'b1;
        repeat (RX_BIT) @(negedge clk);

        rxExpQ.push_back({1'b0, 8'h35});
        applyStimulus(8'h35, 1'b1, 8, RX_BIT);
        repeat (200) @(negedge clk);
        checkOutput("rx35Drained", rxExpQ.size(), 32'd0);
        checkOutput("rx35DoneCnt", rxDoneCnt, 32'd1);
        checkOutput("rx35Idle", {31'd0, rxBusy}, 32'd0);

        rxExpQ.push_back({1'b1, 8'hC3});
        applyStimulus(8'hC3, 1'b0, 8, RX_BIT);
        rx = 1'b1;
        repeat (300) @(negedge clk);
        checkOutput("frameErrDoneCnt", rxDoneCnt, 32'd2);
        checkOutput("frameErrHeld", {31'd0, rxErr}, 32'd1);
        checkOutput("frameErrOut", {24'd0, out}, 32'h0C3);

        rxExpQ.push_back({1'b0, 8'h35});
        applyStimulus(8'h35, 1'b1, 8, RX_BIT);
        repeat (200) @(negedge clk);
        checkOutput("rxAgainDoneCnt", rxDoneCnt, 32'd3);
        checkOutput("rxAgainErr", {31'd0, rxErr}, 32'd0);

        rx = 1'b0;
        repeat (150) @(negedge clk);
        checkOutput("glitchBusy", {31'd0, rxBusy}, 32'd1);
        repeat (3 * (RX_BIT / 16) - 150) @(negedge clk);
        rx = 1'b1;
        repeat (RX_BIT + 50) @(negedge clk);
        checkOutput("glitchIdle", {31'd0, rxBusy}, 32'd0);
        checkOutput("glitchNoDone", rxDoneCnt, 32'd3);
        checkOutput("glitchDrained", rxExpQ.size(), 32'd0);
      end

      begin : txSeq
        logic [7:0] txByte;
        int waitCnt;
        repeat (20) @(negedge clk);
        txByte = 8'hA5;
        txExpQ.push_back(1'b0);
        for (int i = 0; i < 8; i++) txExpQ.push_back(txByte[i]);
        txExpQ.push_back(1'b1);
        in      = txByte;
        txStart = 1'b1;
        @(negedge clk);
        txStart = 1'b0;
        checkOutput("txBusyAccept", {31'd0, txBusy}, 32'd1);
        waitCnt = 0;
        while (tx !== 1'b0 && waitCnt < 2 * TX_BIT) begin
          @(negedge clk);
          waitCnt++;
        end
        checkOutput("txStartBitSeen", {31'd0, tx}, 32'd0);
        if (tx === 1'b0) begin
          in      = 8'hFF;
          txStart = 1'b1;
          @(negedge clk);
          txStart = 1'b0;
          repeat (TX_BIT / 2 - 1) @(negedge clk);
          for (int b = 0; b < 10; b++) begin
            logic expBit;
            expBit = txExpQ.pop_front();
            checkOutput("txBit", {31'd0, tx}, {31'd0, expBit});
            if (b < 9) repeat (TX_BIT) @(negedge clk);
          end
          waitCnt = 0;
          while (txDoneCnt == 0 && waitCnt < TX_BIT + 20) begin
            @(negedge clk);
            waitCnt++;
          end
          repeat (3) @(negedge clk);
          checkOutput("txDoneOnce", txDoneCnt, 32'd1);
          checkOutput("txBusyCleared", {31'd0, txBusy}, 32'd0);
          checkOutput("txIdleHigh", {31'd0, tx}, 32'd1);
          checkOutput("txBusyLength",
                      {31'd0, (txBusyClks >= 10 * TX_BIT && txBusyClks <= 11 * TX_BIT)}, 32'd1);
          repeat (TX_BIT) @(negedge clk);
          checkOutput("txNoExtraFrame", txDoneCnt, 32'd1);
        end
      end
    join

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
